// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between N_REQ masters.
// An in-order ID FIFO routes each memory response back to the requester that issued it.
module tcdm_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      in_req_i,
    input  logic [N_REQ*AW-1:0]   in_add_i,
    input  logic [N_REQ-1:0]      in_wen_i,
    input  logic [N_REQ*DW/8-1:0] in_be_i,
    input  logic [N_REQ*DW-1:0]   in_data_i,
    output logic [N_REQ-1:0]      in_gnt_o,
    output logic [N_REQ*DW-1:0]   in_r_data_o,
    output logic [N_REQ-1:0]      in_r_valid_o,
    output logic                  out_req_o,
    output logic [AW-1:0]         out_add_o,
    output logic                  out_wen_o,
    output logic [DW/8-1:0]       out_be_o,
    output logic [DW-1:0]         out_data_o,
    input  logic                  out_gnt_i,
    input  logic [DW-1:0]         out_r_data_i,
    input  logic                  out_r_valid_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy_o,
    output logic                  err_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = DW / 8;

    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          found;
    logic          full;
    logic          handshake;
    logic          pop;
    logic [IW-1:0] ids [0:(1<<PW)-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] head;
    logic [OW-1:0] occupancy;

    // Cyclic priority scan starting at ptr.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && in_req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Full is taken from registered occupancy, so a same-cycle pop does not unblock.
    assign full      = (occupancy == OW'(FIFO_DEPTH));
    assign out_req_o = (|in_req_i) & ~full & ~rst_i;
    assign handshake = out_req_o & out_gnt_i;
    assign pop       = out_r_valid_i & (occupancy != '0);
    assign head      = ids[rd_ptr];
    assign occupancy_o = occupancy;

    always_comb begin
        out_add_o    = '0;
        out_wen_o    = 1'b0;
        out_be_o     = '0;
        out_data_o   = '0;
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (out_req_o && winner == IW'(k)) begin
                out_add_o  = in_add_i[k*AW +: AW];
                out_wen_o  = in_wen_i[k];
                out_be_o   = in_be_i[k*BW +: BW];
                out_data_o = in_data_i[k*DW +: DW];
                in_gnt_o[k] = out_gnt_i;
            end
            if (pop && head == IW'(k)) begin
                in_r_valid_o[k]          = 1'b1;
                in_r_data_o[k*DW +: DW]  = out_r_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            err_o     <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (handshake && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !handshake) begin
                occupancy <= occupancy - 1'b1;
            end
            // A response with nothing outstanding can never be routed; flag it until reset.
            if (out_r_valid_i && occupancy == '0) begin
                err_o <= 1'b1;
            end
        end
    end

    // ID storage carries no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            ids[wr_ptr] <= winner;
        end
    end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed testbench for tcdm_rr_arbiter (N_REQ=4, FIFO_DEPTH=2).
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_tcdm_rr_arbiter;

    localparam int N  = 4;
    localparam int FD = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_req;
    logic [N*AW-1:0] in_add;
    logic [N-1:0]    in_wen;
    logic [N*DW/8-1:0] in_be;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_gnt;
    logic [N*DW-1:0] in_r_data;
    logic [N-1:0]    in_r_valid;
    logic            out_req;
    logic [AW-1:0]   out_add;
    logic            out_wen;
    logic [DW/8-1:0] out_be;
    logic [DW-1:0]   out_data;
    logic            out_gnt;
    logic [DW-1:0]   out_r_data;
    logic            out_r_valid;
    logic [1:0]      occupancy;
    logic            err;

    int checks = 0;
    int fails  = 0;

    tcdm_rr_arbiter #(.N_REQ(N), .FIFO_DEPTH(FD), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be),
        .in_data_i(in_data), .in_gnt_o(in_gnt), .in_r_data_o(in_r_data),
        .in_r_valid_o(in_r_valid), .out_req_o(out_req), .out_add_o(out_add),
        .out_wen_o(out_wen), .out_be_o(out_be), .out_data_o(out_data),
        .out_gnt_i(out_gnt), .out_r_data_i(out_r_data), .out_r_valid_i(out_r_valid),
        .occupancy_o(occupancy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rdata);
        @(posedge clk);
        #1;
        in_req      = req;
        out_gnt     = gnt;
        out_r_valid = rv;
        out_r_data  = rdata;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_req = 4'hF; out_gnt = 1'b1; out_r_valid = 1'b0;
        #2;
        checks++;
        if (out_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_req got %b want 0", out_req); end
        checks++;
        if (in_gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt got %b want 0000", in_gnt); end
        checks++;
        if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
        checks++;
        if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", err); end
        checks++;
        if (in_r_valid !== 4'b0000) begin fails++; $display("[TB] FAIL reset_rvalid got %b want 0000", in_r_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0; in_req = '0; out_gnt = 1'b0;
    endtask

    // All four requesting: grants rotate 0,1,2,3,0, each answered one cycle later.
    task automatic test_rotation();
        logic [N-1:0] exp_gnt, exp_rv;
        int owner;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive((c < 5) ? 4'hF : 4'h0, 1'b1, (c > 0), 32'hA000_0000 + c);
            exp_gnt = (c < 5) ? (4'b0001 << (c % 4)) : 4'b0000;
            exp_rv  = (c > 0) ? (4'b0001 << ((c - 1) % 4)) : 4'b0000;
            checks++;
            if (in_gnt !== exp_gnt) begin fails++; $display("[TB] FAIL rot_gnt c=%0d got %b want %b", c, in_gnt, exp_gnt); end
            checks++;
            if (in_r_valid !== exp_rv) begin fails++; $display("[TB] FAIL rot_rvalid c=%0d got %b want %b", c, in_r_valid, exp_rv); end
            if (c > 0) begin
                owner = (c - 1) % 4;
                checks++;
                if (in_r_data[owner*DW +: DW] !== 32'hA000_0000 + c) begin
                    fails++;
                    $display("[TB] FAIL rot_rdata c=%0d got %h want %h", c, in_r_data[owner*DW +: DW], 32'hA000_0000 + c);
                end
            end
            checks++;
            if (occupancy !== ((c == 0) ? 2'd0 : 2'd1)) begin
                fails++;
                $display("[TB] FAIL rot_occ c=%0d got %0d want %0d", c, occupancy, (c == 0) ? 0 : 1);
            end
        end
    endtask

    // Get ptr to 3, then req[0] and req[2] only: expect 0, 2, 0 across the wrap.
    task automatic test_wrap();
        logic [N-1:0] gnt_tab [5];
        logic [N-1:0] rv_tab  [5];
        logic [N-1:0] req_tab [5];
        req_tab = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
        gnt_tab = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000};
        rv_tab  = '{4'b0000, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(req_tab[c], 1'b1, (c > 0), 32'h0);
            checks++;
            if (in_gnt !== gnt_tab[c]) begin fails++; $display("[TB] FAIL wrap_gnt c=%0d got %b want %b", c, in_gnt, gnt_tab[c]); end
            checks++;
            if (in_r_valid !== rv_tab[c]) begin fails++; $display("[TB] FAIL wrap_rvalid c=%0d got %b want %b", c, in_r_valid, rv_tab[c]); end
        end
    endtask

    // FIFO_DEPTH=2 with responses withheld; a pop in the full cycle does not unblock it.
    task automatic test_full();
        logic [N-1:0] gnt_tab [8];
        logic [N-1:0] rv_tab  [8];
        logic         rvi_tab [8];
        logic         oreq_tab[8];
        logic [1:0]   occ_tab [8];
        gnt_tab  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        rv_tab   = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000};
        rvi_tab  = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1};
        oreq_tab = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        occ_tab  = '{2'd0,    2'd1,    2'd2,    2'd2,    2'd1,    2'd2,    2'd1,    2'd1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive((c < 7) ? 4'hF : 4'h0, 1'b1, rvi_tab[c], 32'h0);
            checks++;
            if (in_gnt !== gnt_tab[c]) begin fails++; $display("[TB] FAIL full_gnt c=%0d got %b want %b", c, in_gnt, gnt_tab[c]); end
            checks++;
            if (out_req !== oreq_tab[c]) begin fails++; $display("[TB] FAIL full_outreq c=%0d got %b want %b", c, out_req, oreq_tab[c]); end
            checks++;
            if (in_r_valid !== rv_tab[c]) begin fails++; $display("[TB] FAIL full_rvalid c=%0d got %b want %b", c, in_r_valid, rv_tab[c]); end
            checks++;
            if (occupancy !== occ_tab[c]) begin fails++; $display("[TB] FAIL full_occ c=%0d got %0d want %0d", c, occupancy, occ_tab[c]); end
        end
        drive(4'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL full_drain got %0d want 0", occupancy); end
    endtask

    // Read by requester 1 then write by requester 3; responses routed in order.
    task automatic test_mixed();
        do_reset();
        in_add  = '0; in_wen = '0; in_be = '0; in_data = '0;
        in_add[1*AW +: AW]  = 32'h0000_0100; in_wen[1] = 1'b1; in_be[1*4 +: 4] = 4'hF;
        in_add[3*AW +: AW]  = 32'h0000_0104; in_wen[3] = 1'b0; in_be[3*4 +: 4] = 4'h3;
        in_data[3*DW +: DW] = 32'h1234_5678;
        drive(4'b1010, 1'b1, 1'b0, 32'h0);
        checks++;
        if (in_gnt !== 4'b0010) begin fails++; $display("[TB] FAIL mix_gnt1 got %b want 0010", in_gnt); end
        checks++;
        if (out_add !== 32'h100 || out_wen !== 1'b1 || out_be !== 4'hF) begin
            fails++; $display("[TB] FAIL mix_rd_fields got add=%h wen=%b be=%h want 100/1/f", out_add, out_wen, out_be);
        end
        drive(4'b1000, 1'b1, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (in_gnt !== 4'b1000) begin fails++; $display("[TB] FAIL mix_gnt3 got %b want 1000", in_gnt); end
        checks++;
        if (out_add !== 32'h104 || out_wen !== 1'b0 || out_be !== 4'h3 || out_data !== 32'h1234_5678) begin
            fails++; $display("[TB] FAIL mix_wr_fields got add=%h wen=%b be=%h data=%h", out_add, out_wen, out_be, out_data);
        end
        checks++;
        if (in_r_valid !== 4'b0010 || in_r_data[1*DW +: DW] !== 32'hDEAD_BEEF || in_r_data[3*DW +: DW] !== 32'h0) begin
            fails++; $display("[TB] FAIL mix_resp1 got rv=%b d1=%h d3=%h want 0010/deadbeef/0", in_r_valid, in_r_data[1*DW +: DW], in_r_data[3*DW +: DW]);
        end
        drive(4'b0000, 1'b0, 1'b1, 32'h1234_5678);
        checks++;
        if (in_r_valid !== 4'b1000 || in_r_data[3*DW +: DW] !== 32'h1234_5678 || in_r_data[1*DW +: DW] !== 32'h0) begin
            fails++; $display("[TB] FAIL mix_resp3 got rv=%b d3=%h d1=%h want 1000/12345678/0", in_r_valid, in_r_data[3*DW +: DW], in_r_data[1*DW +: DW]);
        end
        checks++;
        if (out_req !== 1'b0 || out_add !== 32'h0) begin
            fails++; $display("[TB] FAIL mix_idle got req=%b add=%h want 0/0", out_req, out_add);
        end
    endtask

    // Stray response with an empty FIFO, then a late response after a mid-flight reset.
    task automatic test_error();
        do_reset();
        drive(4'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checks++;
        if (in_r_valid !== 4'b0000) begin fails++; $display("[TB] FAIL err_rvalid got %b want 0000", in_r_valid); end
        checks++;
        if (err !== 1'b0) begin fails++; $display("[TB] FAIL err_before got %b want 0", err); end
        for (int c = 0; c < 3; c++) begin
            drive(4'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky c=%0d got %b want 1", c, err); end
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin fails++; $display("[TB] FAIL err_cleared got %b want 0", err); end
        drive(4'b0100, 1'b1, 1'b0, 32'h0);
        do_reset();
        drive(4'h0, 1'b0, 1'b1, 32'h5555_5555);
        checks++;
        if (in_r_valid !== 4'b0000 || occupancy !== 2'd0) begin
            fails++; $display("[TB] FAIL err_late_route got rv=%b occ=%0d want 0000/0", in_r_valid, occupancy);
        end
        drive(4'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_late got %b want 1", err); end
    endtask

    initial begin
        rst = 1'b0; in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        out_gnt = 1'b0; out_r_data = '0; out_r_valid = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_full();
        test_mixed();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
